// File: rtl/prbs_pkg.sv
// rtl/prbs_pkg.sv - shared PRBS-15 types, constants and helper functions
package prbs_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    HEADER = 2'd1,
    CHECK  = 2'd2
  } state_t;

  localparam int PRBS_W = 15;
  localparam int TAP_HI = 14;
  localparam int TAP_LO = 13;

  // x^15 + x^14 + 1, shifting toward the MSB
  function automatic logic [PRBS_W-1:0] lfsr15_next(input logic [PRBS_W-1:0] s);
    return {s[PRBS_W-2:0], s[TAP_LO] ^ s[TAP_HI]};
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] b);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'b000, b[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/prbs_checker_if.sv
// rtl/prbs_checker_if.sv - received byte stream from the link/deserializer
interface prbs_checker_if;
  logic       din_valid;
  logic [7:0] din;

  modport master (output din_valid, output din);
  modport slave  (input  din_valid, input  din);
endinterface

// File: rtl/prbs_lfsr15.sv
// rtl/prbs_lfsr15.sv - loadable PRBS-15 state register, one step per adv
module prbs_lfsr15
  import prbs_pkg::*;
(
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              load,
  input  logic [PRBS_W-1:0] seed,
  input  logic              adv,
  output logic [PRBS_W-1:0] state
);

  logic [PRBS_W-1:0] r_state;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state <= '0;
    end else if (load) begin
      r_state <= seed;
    end else if (adv) begin
      r_state <= lfsr15_next(r_state);
    end
  end

  assign state = r_state;

endmodule

// File: rtl/prbs_checker.sv
// rtl/prbs_checker.sv - header hunt, PRBS-15 payload lock and error counting
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int LOSS_THRESH = 4
) (
  input  logic          CLK,
  input  logic          RSTn,
  prbs_checker_if.slave s_in,
  input  logic [7:0]    n,
  input  logic [31:0]   pattern,
  output logic          hdr_fail,
  output logic          locked,
  output logic          err,
  output logic [15:0]   err_cnt,
  output logic [23:0]   bit_err_cnt,
  output logic          lock_lost
);

  localparam logic [8:0] LOSS_T = 9'(LOSS_THRESH);

  state_t        r_state;
  logic [31:0]   r_pattern_cap;
  logic [7:0]    r_n_cap;
  logic [1:0]    r_byte_idx;
  logic [7:0]    r_rep;
  logic [7:0]    r_bad_run;
  logic          r_hdr_fail;
  logic          r_locked;
  logic          r_err;
  logic          r_lock_lost;
  logic [15:0]   r_err_cnt;
  logic [23:0]   r_bit_err_cnt;

  state_t        w_state_nxt;
  logic [14:0]   w_lfsr;
  logic          w_load;
  logic          w_adv;
  logic          w_hunt_hit;
  logic          w_hdr_hit;
  logic          w_hdr_fail;
  logic          w_err;
  logic          w_lock_lost;
  logic [7:0]    w_exp_hdr;
  logic [8:0]    w_bad_inc;
  logic [24:0]   w_bit_sum;
  logic          w_unused;

  prbs_lfsr15 u_lfsr (
    .CLK   (CLK),
    .RSTn  (RSTn),
    .load  (w_load),
    .seed  (r_pattern_cap[14:0]),
    .adv   (w_adv),
    .state (w_lfsr)
  );

  assign w_unused  = ^w_lfsr[14:8];
  assign w_bad_inc = {1'b0, r_bad_run} + 9'd1;
  assign w_bit_sum = {1'b0, r_bit_err_cnt} + {21'd0, popcount8(s_in.din ^ w_lfsr[7:0])};

  always_comb begin
    w_exp_hdr = r_pattern_cap[31:24];
    case (r_byte_idx)
      2'd1:    w_exp_hdr = r_pattern_cap[23:16];
      2'd2:    w_exp_hdr = r_pattern_cap[15:8];
      2'd3:    w_exp_hdr = r_pattern_cap[7:0];
      default: w_exp_hdr = r_pattern_cap[31:24];
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_adv       = 1'b0;
    w_hunt_hit  = 1'b0;
    w_hdr_hit   = 1'b0;
    w_hdr_fail  = 1'b0;
    w_err       = 1'b0;
    w_lock_lost = 1'b0;
    if (s_in.din_valid) begin
      case (r_state)
        HUNT: begin
          if (s_in.din == pattern[31:24]) begin
            w_hunt_hit  = 1'b1;
            w_state_nxt = HEADER;
          end
        end
        HEADER: begin
          if (s_in.din == w_exp_hdr) begin
            w_hdr_hit = 1'b1;
            // 8-bit compare: a captured n of 0 wraps to 255 and yields 256 reps
            if (r_byte_idx == 2'd3 && r_rep == r_n_cap - 8'd1) begin
              w_load      = 1'b1;
              w_state_nxt = CHECK;
            end
          end else begin
            w_hdr_fail  = 1'b1;
            w_state_nxt = HUNT;
          end
        end
        CHECK: begin
          w_adv = 1'b1;
          if (s_in.din != w_lfsr[7:0]) begin
            w_err = 1'b1;
            if (w_bad_inc == LOSS_T) begin
              w_lock_lost = 1'b1;
              w_state_nxt = HUNT;
            end
          end
        end
        default: w_state_nxt = HUNT;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state <= HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_pattern_cap <= '0;
      r_n_cap       <= '0;
      r_byte_idx    <= '0;
      r_rep         <= '0;
      r_bad_run     <= '0;
      r_hdr_fail    <= 1'b0;
      r_locked      <= 1'b0;
      r_err         <= 1'b0;
      r_lock_lost   <= 1'b0;
      r_err_cnt     <= '0;
      r_bit_err_cnt <= '0;
    end else begin
      r_hdr_fail  <= w_hdr_fail;
      r_err       <= w_err;
      r_lock_lost <= w_lock_lost;
      r_locked    <= (w_state_nxt == CHECK);
      if (w_hunt_hit) begin
        r_pattern_cap <= pattern;
        r_n_cap       <= n;
        r_byte_idx    <= 2'd1;
        r_rep         <= 8'd0;
      end else if (w_hdr_hit) begin
        r_byte_idx <= r_byte_idx + 2'd1;
        if (r_byte_idx == 2'd3) begin
          r_rep <= r_rep + 8'd1;
        end
      end
      if (w_adv) begin
        if (w_err) begin
          r_err_cnt     <= (&r_err_cnt) ? r_err_cnt : r_err_cnt + 16'd1;
          r_bit_err_cnt <= w_bit_sum[24] ? 24'hFF_FFFF : w_bit_sum[23:0];
          r_bad_run     <= w_lock_lost ? 8'd0 : w_bad_inc[7:0];
        end else begin
          r_bad_run <= 8'd0;
        end
      end
    end
  end

  assign hdr_fail    = r_hdr_fail;
  assign locked      = r_locked;
  assign err         = r_err;
  assign err_cnt     = r_err_cnt;
  assign bit_err_cnt = r_bit_err_cnt;
  assign lock_lost   = r_lock_lost;

endmodule

// File: tb/tb_prbs_checker.sv
// tb/tb_prbs_checker.sv - directed bench with a byte-count reference model of the checker
module tb_prbs_checker;

  localparam int THRESH = 4;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic [7:0]  n = 8'd2;
  logic [31:0] pattern = 32'hDEADBEEF;

  logic        hdr_fail, locked, err, lock_lost;
  logic [15:0] err_cnt;
  logic [23:0] bit_err_cnt;
  logic        b_hdr_fail, b_locked, b_err, b_lock_lost;
  logic [15:0] b_err_cnt;
  logic [23:0] b_bit_err_cnt;

  always #5 CLK = ~CLK;

  prbs_checker_if u_if ();

  prbs_checker #(.LOSS_THRESH(THRESH)) u_dut (
    .CLK(CLK), .RSTn(RSTn), .s_in(u_if.slave), .n(n), .pattern(pattern),
    .hdr_fail(hdr_fail), .locked(locked), .err(err), .err_cnt(err_cnt),
    .bit_err_cnt(bit_err_cnt), .lock_lost(lock_lost)
  );

  // Long-threshold instance used only to reach counter saturation while staying locked
  prbs_checker #(.LOSS_THRESH(255)) u_sat (
    .CLK(CLK), .RSTn(RSTn), .s_in(u_if.slave), .n(n), .pattern(pattern),
    .hdr_fail(b_hdr_fail), .locked(b_locked), .err(b_err), .err_cnt(b_err_cnt),
    .bit_err_cnt(b_bit_err_cnt), .lock_lost(b_lock_lost)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int prbs_step(input int s);
    return ((s << 1) | (((s >> 14) ^ (s >> 13)) & 1)) & 'h7FFF;
  endfunction

  // Reference model: tracks header progress as a count of matched bytes
  int          m_mode = 0;
  int          m_k = 0;
  int          m_ncap = 0;
  int          m_bad = 0;
  int          m_lfsr = 0;
  int          x_exp = 0;
  logic [31:0] m_pat = '0;
  logic        e_hdr_fail = 0, e_err = 0, e_lock_lost = 0, e_locked = 0;
  int          e_err_cnt = 0, e_bit_cnt = 0;

  initial forever begin
    @(posedge CLK or negedge RSTn);
    if (!RSTn) begin
      m_mode = 0; m_k = 0; m_bad = 0; m_lfsr = 0;
      e_hdr_fail = 0; e_err = 0; e_lock_lost = 0; e_locked = 0;
      e_err_cnt = 0; e_bit_cnt = 0;
    end else begin
      e_hdr_fail = 0; e_err = 0; e_lock_lost = 0;
      if (u_if.din_valid) begin
        if (m_mode == 0) begin
          if (u_if.din == pattern[31:24]) begin
            m_pat = pattern; m_ncap = (n == 0) ? 256 : int'(n); m_k = 1; m_mode = 1;
          end
        end else if (m_mode == 1) begin
          x_exp = int'((m_pat >> (8 * (3 - (m_k % 4)))) & 32'hFF);
          if (u_if.din == 8'(x_exp)) begin
            m_k++;
            if (m_k == 4 * m_ncap) begin
              m_mode = 2; e_locked = 1; m_lfsr = int'(m_pat & 32'h7FFF);
            end
          end else begin
            e_hdr_fail = 1; m_mode = 0;
          end
        end else begin
          x_exp = m_lfsr & 'hFF;
          m_lfsr = prbs_step(m_lfsr);
          if (u_if.din != 8'(x_exp)) begin
            e_err = 1;
            if (e_err_cnt < 65535) e_err_cnt++;
            e_bit_cnt = e_bit_cnt + $countones(u_if.din ^ 8'(x_exp));
            if (e_bit_cnt > 24'hFFFFFF) e_bit_cnt = 24'hFFFFFF;
            m_bad++;
            if (m_bad == THRESH) begin
              e_lock_lost = 1; m_bad = 0; m_mode = 0; e_locked = 0;
            end
          end else begin
            m_bad = 0;
          end
        end
      end
    end
  end

  initial forever begin
    @(posedge CLK);
    #1;
    if (RSTn) begin
      check("hdr_fail", 32'(hdr_fail), 32'(e_hdr_fail));
      check("locked", 32'(locked), 32'(e_locked));
      check("err", 32'(err), 32'(e_err));
      check("lock_lost", 32'(lock_lost), 32'(e_lock_lost));
      check("err_cnt", 32'(err_cnt), e_err_cnt);
      check("bit_err_cnt", 32'(bit_err_cnt), e_bit_cnt);
    end
  end

  logic gap_en = 1'b0;
  int   g_lfsr = 0;

  task automatic send(input logic [7:0] b);
    if (gap_en) begin
      int g;
      g = $urandom_range(0, 2);
      for (int i = 0; i < g; i++) begin
        @(negedge CLK); u_if.din_valid = 1'b0; u_if.din = 8'($urandom);
      end
    end
    @(negedge CLK); u_if.din_valid = 1'b1; u_if.din = b;
  endtask

  task automatic idle(input int c);
    for (int i = 0; i < c; i++) begin
      @(negedge CLK); u_if.din_valid = 1'b0; u_if.din = 8'h00;
    end
  endtask

  task automatic smp();
    @(posedge CLK); #1;
  endtask

  task automatic hdr_bytes(input logic [31:0] p, input int first, input int last);
    for (int k = first; k < last; k++) send(p[8 * (3 - (k % 4)) +: 8]);
    g_lfsr = int'(p[14:0]);
  endtask

  task automatic pay(input int c);
    for (int i = 0; i < c; i++) begin send(8'(g_lfsr)); g_lfsr = prbs_step(g_lfsr); end
  endtask

  task automatic pay_x(input logic [7:0] mask);
    send(8'(g_lfsr) ^ mask); g_lfsr = prbs_step(g_lfsr);
  endtask

  task automatic pay_f(input logic [7:0] v);
    send(v); g_lfsr = prbs_step(g_lfsr);
  endtask

  task automatic do_reset();
    @(negedge CLK); u_if.din_valid = 1'b0; RSTn = 1'b0;
    @(negedge CLK); RSTn = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_hdr_fail"}, 32'(hdr_fail), 0);
    check({tag, "_locked"}, 32'(locked), 0);
    check({tag, "_err"}, 32'(err), 0);
    check({tag, "_lock_lost"}, 32'(lock_lost), 0);
    check({tag, "_err_cnt"}, 32'(err_cnt), 0);
    check({tag, "_bit_err_cnt"}, 32'(bit_err_cnt), 0);
  endtask

  initial begin
    int s;
    u_if.din_valid = 1'b0;
    u_if.din = 8'h00;

    smp();
    check_all_zero("reset");
    check("sat_reset_err_cnt", 32'(b_err_cnt), 0);
    check("sat_reset_locked", 32'(b_locked), 0);
    check("sat_reset_pulses", {29'd0, b_hdr_fail, b_err, b_lock_lost}, 0);
    check("sat_reset_bits", 32'(b_bit_err_cnt), 0);

    s = 'h3EEF;
    check("model_seed_byte", s & 'hFF, 32'hEF);
    s = prbs_step(s); check("model_step1", s, 32'h7DDF);
    s = prbs_step(s); check("model_step2", s, 32'h7BBE);
    s = prbs_step(s); check("model_step3", s, 32'h777C);

    @(negedge CLK); RSTn = 1'b1;
    idle(3);

    // clean link
    pattern = 32'hDEADBEEF; n = 8'd2;
    hdr_bytes(pattern, 0, 7); smp();
    check("locked_before_8th", 32'(locked), 0);
    hdr_bytes(pattern, 7, 8); smp();
    check("locked_after_8th", 32'(locked), 1);
    pay(2000); smp();
    check("clean_err_cnt", 32'(err_cnt), 0);
    check("clean_bit_cnt", 32'(bit_err_cnt), 0);

    // error injection
    pay(9); pay_x(8'h01); pay(9); pay_x(8'hFF); pay(5); smp();
    check("inj_err_cnt", 32'(err_cnt), 2);
    check("inj_bit_cnt", 32'(bit_err_cnt), 9);
    check("inj_locked", 32'(locked), 1);

    // three bad then one good twice keeps lock
    for (int r = 0; r < 2; r++) begin
      pay_x(8'hFF); pay_x(8'hFF); pay_x(8'hFF); pay(1);
    end
    smp();
    check("run3_locked", 32'(locked), 1);
    check("run3_err_cnt", 32'(err_cnt), 8);
    check("run3_bit_cnt", 32'(bit_err_cnt), 57);
    idle(1);

    // lock loss on fresh counters
    do_reset();
    hdr_bytes(pattern, 0, 8);
    pay_f(8'h00); pay_f(8'h00); pay_f(8'h00); smp();
    check("loss_pre_pulse", 32'(lock_lost), 0);
    check("loss_pre_locked", 32'(locked), 1);
    pay_f(8'h00); smp();
    check("loss_pulse", 32'(lock_lost), 1);
    check("loss_locked", 32'(locked), 0);
    check("loss_err_cnt", 32'(err_cnt), 4);
    check("loss_bit_cnt", 32'(bit_err_cnt), 25);
    idle(2);

    // header failure then relock
    hdr_bytes(pattern, 0, 2); send(8'hBF); smp();
    check("hdrfail_pulse", 32'(hdr_fail), 1);
    check("hdrfail_locked", 32'(locked), 0);
    idle(1);
    hdr_bytes(pattern, 0, 8); pay(50); smp();
    check("relock_locked", 32'(locked), 1);

    // asynchronous reset while locked
    @(negedge CLK); u_if.din_valid = 1'b0;
    #2 RSTn = 1'b0;
    #1 check_all_zero("async_rst");
    @(negedge CLK); RSTn = 1'b1;
    hdr_bytes(pattern, 0, 8); pay(100); smp();
    check("post_rst_locked", 32'(locked), 1);

    // valid gaps during payload
    gap_en = 1'b1;
    pay(500);
    gap_en = 1'b0;
    smp();
    check("gap_err_cnt", 32'(err_cnt), 0);
    check("gap_locked", 32'(locked), 1);
    idle(1);

    // n = 0 means 256 repetitions
    do_reset();
    n = 8'd0;
    hdr_bytes(pattern, 0, 1023); smp();
    check("n0_locked_1023", 32'(locked), 0);
    hdr_bytes(pattern, 1023, 1024); smp();
    check("n0_locked_1024", 32'(locked), 1);
    pay(20); smp();
    check("n0_err_cnt", 32'(err_cnt), 0);
    idle(1);

    // counter saturation on the long-threshold instance
    do_reset();
    n = 8'd1;
    hdr_bytes(pattern, 0, 4);
    for (int gi = 0; gi < 259; gi++) begin
      for (int j = 0; j < 254; j++) pay_x(8'hFF);
      pay(1);
    end
    smp();
    check("sat_err_cnt", 32'(b_err_cnt), 32'hFFFF);
    check("sat_bit_cnt", 32'(b_bit_err_cnt), 526288);
    check("sat_locked", 32'(b_locked), 1);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
